stack_cmd_frontend: RTL and testbench
=====================================

STACK_CMD_FRONTEND -- requirements
Module: stack_cmd_frontend

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning consecutive cycles a synchronised button level must differ from its debounced level before that level flips; legal range 2..65535.
REQ-002 SHALL have port clock  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports btn_enter, btn_check, btn_add, btn_swap, btn_pop  input  1 each  raw asynchronous push-buttons, active-high.
REQ-005 SHALL have port sw_data  input  8  raw operand switches, sampled at issue time.
REQ-006 SHALL have port write_opcode  output  4  one-cycle command to the stack datapath: 0000 idle, 0001 enter, 0010 check, 0011 add, 0100 swap, 0101 pop.
REQ-007 SHALL have port data  output  8  operand accompanying write_opcode.
REQ-008 SHALL have port busy  output  1  high during post-command lockout cycles.
REQ-009 SHALL have port pending  output  5  queued requests {pop,swap,add,check,enter}, MSB to LSB.
REQ-010 SHALL have port issued_count  output  8  number of commands issued, wrapping.

Function
REQ-011 Each button SHALL pass through a 2-flop synchroniser, then its own debouncer.
REQ-012 Debouncer: counter clears whenever the synced level equals the debounced level; otherwise it increments; on the cycle it would reach DEBOUNCE_CYCLES the debounced level flips and the counter clears.
REQ-013 A 0->1 transition of a debounced level SHALL set the matching pending bit on the next clock edge; 1->0 transitions SHALL be ignored.
REQ-014 A rising edge on a button whose pending bit is already set SHALL be merged (no second command).
REQ-015 Issue rule: when not busy and pending nonzero, on the next edge issue the highest-priority pending request (enter > check > add > swap > pop), register its opcode on write_opcode, and clear that pending bit in the same edge.
REQ-016 A pending bit set and issued at the same edge SHALL end cleared; an edge arriving the cycle its bit clears SHALL re-queue.
REQ-017 data SHALL be loaded with synchronised sw_data (2-flop, 8 bits) at the edge an enter command is issued and SHALL hold otherwise.
REQ-018 write_opcode SHALL be nonzero for exactly one cycle per issued command and 0000 at all other times.
REQ-019 Lockout after issue: add -> 1 cycle, swap -> 2 cycles, enter/check/pop -> 0 cycles; busy high and write_opcode 0000 throughout; back-to-back issue allowed after 0-cycle commands.
REQ-020 States: IDLE (no issue), ISSUE (write_opcode valid), LOCK (busy, down-counter 2 bits); ISSUE->LOCK if lockout>0, ISSUE->ISSUE if lockout 0 and pending nonzero, else ->IDLE; LOCK->IDLE/ISSUE when counter expires.
REQ-021 issued_count SHALL increment by 1 on each issue, wrapping 255->0.
REQ-022 New edges during LOCK SHALL be queued, not lost.

Reset
REQ-023 On reset: write_opcode=0000, data=00, busy=0, pending=00000, issued_count=00, state IDLE, all debounced levels=0, all debounce counters=0, synchronisers=0.
REQ-024 Reset asserted mid-lockout or mid-issue SHALL abort immediately; no command issues in the cycle after reset deasserts unless a debounced edge occurs afterward.
REQ-025 A button held through reset SHALL produce exactly one enter/other command after reset deasserts, once debounced.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 sw_data=0x5A, hold btn_enter 20 cycles -> one cycle write_opcode=0001, data=0x5A, within 2+4+2 cycles of press; issued_count=1.
REQ-027 btn_enter glitch high 3 cycles then low -> no command, pending stays 00000.
REQ-028 btn_add then btn_enter pressed same cycle -> 0001 issued, next cycle 0011, then 1 busy cycle with 0000, then idle.
REQ-029 btn_swap and btn_pop same cycle -> 0100, busy 2 cycles, then 0101; exact gaps checked.
REQ-030 press btn_check twice within a pending window (second edge before issue) -> one 0010 only; 256 presses total -> issued_count wraps to 00.
REQ-031 reset pulsed during swap lockout -> busy=0, pending=00000 next cycle, no further opcode until new press.

Source files
------------

// File: rtl/stack_cmd_frontend.sv
// stack_cmd_frontend: turns five raw push-buttons into one-cycle stack
// datapath commands.
//   clock, reset          rising-edge clock, synchronous active-high reset
//   btn_enter..btn_pop    raw asynchronous buttons, active-high
//   sw_data[7:0]          raw operand switches (synchronised, taken on enter)
//   write_opcode[3:0]     one-cycle command: 1 enter, 2 check, 3 add, 4 swap, 5 pop
//   data[7:0]             operand latched when an enter issues
//   busy                  high while a post-command lockout runs
//   pending[4:0]          queued requests {pop,swap,add,check,enter}
//   issued_count[7:0]     wrapping count of issued commands
//
// stack_cmd_debounce: per-button 2-flop synchroniser + debouncer, emitting a
// one-cycle pulse on each 0->1 transition of the debounced level.

module stack_cmd_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic rise
);
    localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

    logic [1:0]  sync;
    logic        level;
    logic        level_q;
    logic [15:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync    <= '0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync    <= {sync[0], btn};
            level_q <= level;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                // this cycle would make the disagreement DEBOUNCE_CYCLES long
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    assign rise = level & ~level_q;
endmodule

module stack_cmd_frontend #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_enter,
    input  logic       btn_check,
    input  logic       btn_add,
    input  logic       btn_swap,
    input  logic       btn_pop,
    input  logic [7:0] sw_data,
    output logic [3:0] write_opcode,
    output logic [7:0] data,
    output logic       busy,
    output logic [4:0] pending,
    output logic [7:0] issued_count
);
    localparam logic [3:0] OP_ENTER = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SWAP  = 4'd4;

    typedef enum logic [1:0] {IDLE, ISSUE, LOCK} state_t;

    state_t     state, state_next;
    logic [4:0] btn_vec, rise_vec, clr;
    logic [7:0] sw_s1, sw_s2;
    logic [3:0] sel_op;
    logic [1:0] lock_len, lcnt;
    logic       go;

    assign btn_vec = {btn_pop, btn_swap, btn_add, btn_check, btn_enter};

    stack_cmd_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [4:0] (
        .clock (clock),
        .reset (reset),
        .btn   (btn_vec),
        .rise  (rise_vec)
    );

    // lowest pending index wins (enter highest priority); opcode = index + 1
    always_comb begin
        sel_op = 4'd0;
        clr    = '0;
        for (int i = 4; i >= 0; i--) begin
            if (pending[i]) begin
                sel_op = 4'(i + 1);
                clr    = '0;
                clr[i] = 1'b1;
            end
        end
    end

    // lockout length of the command currently on write_opcode
    always_comb begin
        lock_len = 2'd0;
        if (write_opcode == OP_ADD)  lock_len = 2'd1;
        if (write_opcode == OP_SWAP) lock_len = 2'd2;
    end

    always_comb begin
        go         = 1'b0;
        state_next = IDLE;
        case (state)
            IDLE:  go = |pending;
            ISSUE: go = (lock_len == 2'd0) && |pending;
            LOCK:  go = (lcnt == 2'd0) && |pending;
            default: go = 1'b0;
        endcase
        if (go)
            state_next = ISSUE;
        else if (state == ISSUE && lock_len != 2'd0)
            state_next = LOCK;
        else if (state == LOCK && lcnt != 2'd0)
            state_next = LOCK;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            write_opcode <= '0;
            data         <= '0;
            pending      <= '0;
            issued_count <= '0;
            lcnt         <= '0;
            sw_s1        <= '0;
            sw_s2        <= '0;
        end else begin
            state        <= state_next;
            sw_s1        <= sw_data;
            sw_s2        <= sw_s1;
            // an edge on a bit issued this edge merges; one arriving later re-queues
            pending      <= (pending | rise_vec) & ~(go ? clr : 5'd0);
            write_opcode <= go ? sel_op : 4'd0;
            if (go) issued_count <= issued_count + 8'd1;
            if (go && sel_op == OP_ENTER) data <= sw_s2;
            if (state == ISSUE && state_next == LOCK)
                lcnt <= lock_len - 2'd1;
            else if (state == LOCK && lcnt != 2'd0)
                lcnt <= lcnt - 2'd1;
        end
    end

    assign busy = (state == LOCK);
endmodule

// File: tb/tb_stack_cmd_frontend.sv
module tb_stack_cmd_frontend;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       btn_enter = 0, btn_check = 0, btn_add = 0, btn_swap = 0, btn_pop = 0;
    logic [7:0] sw_data = 8'h00;
    logic [3:0] write_opcode;
    logic [7:0] data;
    logic       busy;
    logic [4:0] pending;
    logic [7:0] issued_count;

    int n_cmp = 0;
    int n_bad = 0;
    int op_seen = 0;

    stack_cmd_frontend #(.DEBOUNCE_CYCLES(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .btn_enter    (btn_enter),
        .btn_check    (btn_check),
        .btn_add      (btn_add),
        .btn_swap     (btn_swap),
        .btn_pop      (btn_pop),
        .sw_data      (sw_data),
        .write_opcode (write_opcode),
        .data         (data),
        .busy         (busy),
        .pending      (pending),
        .issued_count (issued_count)
    );

    always #5 clock = ~clock;

    always @(negedge clock)
        if (write_opcode != 4'd0) op_seen++;

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // steps until write_opcode goes nonzero; k = step count, limit+1 on timeout
    task automatic wait_op(input int limit, output int k);
        k = limit + 1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (write_opcode != 4'd0) begin
                k = i;
                break;
            end
        end
    endtask

    initial begin
        int k;
        int base;
        logic seen_pend;

        // reset state
        step(3);
        reset = 1'b0;
        chk("rst_opcode", 32'(write_opcode), 0);
        chk("rst_data", 32'(data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_count", 32'(issued_count), 0);

        // enter with operand 5A: 2 sync + 4 debounce + 2 (pending, issue)
        sw_data = 8'h5A;
        btn_enter = 1'b1;
        wait_op(30, k);
        chk("enter_latency", 32'(k), 8);
        chk("enter_opcode", 32'(write_opcode), 1);
        chk("enter_data", 32'(data), 32'h5A);
        chk("enter_count", 32'(issued_count), 1);
        step();
        chk("enter_one_cycle", 32'(write_opcode), 0);
        step(11);
        btn_enter = 1'b0;
        step(12);
        chk("enter_single", 32'(op_seen), 1);
        chk("enter_pend_clear", 32'(pending), 0);

        // 3-cycle glitch never debounces
        base = op_seen;
        seen_pend = 1'b0;
        btn_enter = 1'b1;
        step(3);
        btn_enter = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            seen_pend |= (pending != 5'd0);
        end
        chk("glitch_pending", 32'(seen_pend), 0);
        chk("glitch_no_cmd", 32'(op_seen - base), 0);

        // add + enter together: enter first, add back-to-back, one busy cycle
        sw_data = 8'h3C;
        step(3);
        btn_add = 1'b1;
        btn_enter = 1'b1;
        wait_op(30, k);
        chk("ae_latency", 32'(k), 8);
        chk("ae_op_enter", 32'(write_opcode), 1);
        chk("ae_data", 32'(data), 32'h3C);
        step();
        chk("ae_op_add", 32'(write_opcode), 3);
        chk("ae_add_busy", 32'(busy), 0);
        step();
        chk("ae_lock_op", 32'(write_opcode), 0);
        chk("ae_lock_busy", 32'(busy), 1);
        step();
        chk("ae_idle_op", 32'(write_opcode), 0);
        chk("ae_idle_busy", 32'(busy), 0);
        chk("ae_count", 32'(issued_count), 3);
        btn_add = 1'b0;
        btn_enter = 1'b0;
        step(12);

        // swap + pop together: swap, two busy cycles, then pop
        btn_swap = 1'b1;
        btn_pop = 1'b1;
        wait_op(30, k);
        chk("sp_op_swap", 32'(write_opcode), 4);
        step();
        chk("sp_lock1", 32'({busy, write_opcode}), 32'h10);
        step();
        chk("sp_lock2", 32'({busy, write_opcode}), 32'h10);
        step();
        chk("sp_op_pop", 32'({busy, write_opcode}), 32'h05);
        step();
        chk("sp_after", 32'({busy, write_opcode}), 32'h00);
        chk("sp_count", 32'(issued_count), 5);
        btn_swap = 1'b0;
        btn_pop = 1'b0;
        step(12);

        // bouncy double press of check -> one command
        base = op_seen;
        btn_check = 1'b1;
        step(5);
        btn_check = 1'b0;
        step(2);
        btn_check = 1'b1;
        step(8);
        btn_check = 1'b0;
        step(12);
        chk("check_merge", 32'(op_seen - base), 1);
        chk("check_count", 32'(issued_count), 6);

        // 250 more checks -> 256 issued, counter wraps to 0
        for (int i = 0; i < 250; i++) begin
            btn_check = 1'b1;
            step(8);
            btn_check = 1'b0;
            step(8);
        end
        step(4);
        chk("wrap_seen", 32'(op_seen), 256);
        chk("wrap_count", 32'(issued_count), 0);

        // reset during swap lockout aborts everything
        btn_swap = 1'b1;
        btn_pop = 1'b1;
        wait_op(30, k);
        chk("rl_op_swap", 32'(write_opcode), 4);
        step();
        chk("rl_busy", 32'(busy), 1);
        reset = 1'b1;
        btn_swap = 1'b0;
        btn_pop = 1'b0;
        step();
        chk("rl_busy_clr", 32'(busy), 0);
        chk("rl_pending_clr", 32'(pending), 0);
        chk("rl_op_clr", 32'(write_opcode), 0);
        chk("rl_count_clr", 32'(issued_count), 0);
        chk("rl_data_clr", 32'(data), 0);
        reset = 1'b0;
        base = op_seen;
        step(15);
        chk("rl_no_cmd", 32'(op_seen - base), 0);

        // button held through reset -> exactly one command after release of reset
        btn_add = 1'b1;
        step(2);
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        base = op_seen;
        wait_op(30, k);
        chk("held_latency", 32'(k), 8);
        chk("held_op", 32'(write_opcode), 3);
        step(10);
        btn_add = 1'b0;
        step(12);
        chk("held_single", 32'(op_seen - base), 1);
        chk("held_count", 32'(issued_count), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
